servo_pwm_bank: RTL and testbench

Parametrised multi-channel servo PWM generator: the next generation of the single-channel servo driver. It runs on the one system clock with an internal tick prescaler instead of externally divided clocks. Each channel has a programmable pulse width, loaded over a simple write port and applied glitch-free at frame boundaries, with optional per-frame slew limiting. It sits between the control FSM, which writes target widths, and the servo output pins.

---
 rtl/servo_pwm_bank.sv | 181 ++++++++++++++++++
 tb/tb_servo_pwm_bank.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: N_CH servo PWM channels driven from one system clock through a tick prescaler.
// Latency: a write lands in target and raises wr_ack one clock after wr_en; widths apply at the next frame wrap; pwm_out lags tick_cnt by one clock.
// Backpressure: none; every wr_en is accepted and acknowledged, back-to-back writes included.
// Optional feature: define SERVO_SLEW_EN to limit each channel's width change to SLEW_STEP ticks per frame.
module servo_pwm_bank #(
  parameter int N_CH         = 4,
  parameter int CLK_HZ       = 50_000_000,
  parameter int TICK_HZ      = 10_000,
  parameter int PERIOD_TICKS = 200,
  parameter int MIN_TICKS    = 5,
  parameter int MAX_TICKS    = 25,
  parameter int CENTER_TICKS = 15,
  parameter int SLEW_STEP    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [3:0]      wr_ch,
  input  logic [7:0]      wr_width,
  input  logic [N_CH-1:0] ch_en,
  output logic            wr_ack,
  output logic            wr_err,
  output logic            frame_start,
  output logic [N_CH-1:0] pwm_out
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [7:0]    TICK_LAST = 8'(PERIOD_TICKS - 1);
  localparam logic [7:0]    MIN_W     = 8'(MIN_TICKS);
  localparam logic [7:0]    MAX_W     = 8'(MAX_TICKS);
  localparam logic [7:0]    CTR_W     = 8'(CENTER_TICKS);
  localparam logic [4:0]    NCH_W     = 5'(N_CH);

  // Parameter sanity: a bad configuration must not elaborate.
  if (N_CH < 1 || N_CH > 16) begin : g_chk_nch
    $error("servo_pwm_bank: N_CH must be in 1..16");
  end
  if (MAX_TICKS >= PERIOD_TICKS) begin : g_chk_max
    $error("servo_pwm_bank: MAX_TICKS must be below PERIOD_TICKS");
  end
  if (MIN_TICKS > CENTER_TICKS || CENTER_TICKS > MAX_TICKS) begin : g_chk_ctr
    $error("servo_pwm_bank: need MIN_TICKS <= CENTER_TICKS <= MAX_TICKS");
  end
  if (PERIOD_TICKS > 255) begin : g_chk_period
    $error("servo_pwm_bank: PERIOD_TICKS must fit the 8-bit tick counter");
  end
  if (DIV < 2) begin : g_chk_div
    $error("servo_pwm_bank: CLK_HZ/TICK_HZ must be at least 2");
  end
  // A negative step has no meaning whether or not slew limiting is built in.
  if (SLEW_STEP < 0) begin : g_chk_step
    $error("servo_pwm_bank: SLEW_STEP must not be negative");
  end

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [7:0]    tick_cnt;
  logic          wrap;
  logic          ch_ok;
  logic          wr_valid;
  logic [7:0]    wr_clamped;
  logic [7:0]    target     [N_CH];
  logic [7:0]    active     [N_CH];
  logic [7:0]    active_nxt [N_CH];

  assign tick     = (pre_cnt == PRE_LAST);
  assign wrap     = tick && (tick_cnt == TICK_LAST);
  assign ch_ok    = ({1'b0, wr_ch} < NCH_W);
  assign wr_valid = wr_en && ch_ok;

  // Prescaler: divides the system clock down to one tick every DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Frame position in ticks; frame_start marks the clock where it has just wrapped to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt    <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (wrap) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= tick_cnt + 8'd1;
      end
    end
  end

  // Silent clamp of the requested width into the legal servo range.
  always_comb begin
    wr_clamped = wr_width;
    if (wr_width < MIN_W) begin
      wr_clamped = MIN_W;
    end else if (wr_width > MAX_W) begin
      wr_clamped = MAX_W;
    end
  end

  // Write port: valid writes update the target; every strobe is acknowledged next clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        target[i] <= CTR_W;
      end
    end else begin
      wr_ack <= wr_en;
      wr_err <= wr_en && !ch_ok;
      for (int i = 0; i < N_CH; i++) begin
        if (wr_valid && (wr_ch == 4'(i))) begin
          target[i] <= wr_clamped;
        end
      end
    end
  end

`ifdef SERVO_SLEW_EN
  localparam logic [7:0] STEP_W = 8'(SLEW_STEP);

  // Width the next frame will use: step toward target by at most STEP_W.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      active_nxt[i] = target[i];
      if (target[i] > active[i]) begin
        if ((target[i] - active[i]) > STEP_W) begin
          active_nxt[i] = active[i] + STEP_W;
        end
      end else begin
        if ((active[i] - target[i]) > STEP_W) begin
          active_nxt[i] = active[i] - STEP_W;
        end
      end
    end
  end
`else
  // Width the next frame will use: the target, unfiltered.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      active_nxt[i] = target[i];
    end
  end
`endif

  // Active widths only change at the wrap, so a frame in progress is never cut or stretched.
  // A write sampled on the wrap edge is not seen here until the following wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        active[i] <= CTR_W;
      end
    end else if (wrap) begin
      for (int i = 0; i < N_CH; i++) begin
        active[i] <= active_nxt[i];
      end
    end
  end

  // Registered compare; the enable gates the pin without realigning the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        pwm_out[i] <= ch_en[i] && (tick_cnt < active[i]);
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// tb_servo_pwm_bank: directed bench for servo_pwm_bank with DIV = 10, so one frame is 2000 clocks.
// Pulse widths are measured by counting high samples per frame and compared with hand-computed tables.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_servo_pwm_bank;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         wr_en;
  logic [3:0]   wr_ch;
  logic [7:0]   wr_width;
  logic [N-1:0] ch_en;
  logic         wr_ack;
  logic         wr_err;
  logic         frame_start;
  logic [N-1:0] pwm_out;

  int n_cmp;
  int n_bad;
  int hi [N];
  int period;
  int ack_cnt;
  int err_cnt;
  int exp_w [7][N];
  int slew_seq [7];

  servo_pwm_bank #(
    .N_CH(N),
    .CLK_HZ(100_000),
    .TICK_HZ(10_000),
    .PERIOD_TICKS(200),
    .MIN_TICKS(5),
    .MAX_TICKS(25),
    .CENTER_TICKS(15),
    .SLEW_STEP(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_width(wr_width),
    .ch_en(ch_en),
    .wr_ack(wr_ack),
    .wr_err(wr_err),
    .frame_start(frame_start),
    .pwm_out(pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Runs one frame starting on a frame_start sample, optionally issuing up to two
  // consecutive writes starting at cycle 'at'; ends on the next frame_start sample.
  task automatic run_frame(input int nwr, input int at,
                           input logic [3:0] c0, input logic [7:0] w0,
                           input logic [3:0] c1, input logic [7:0] w1);
    int n;
    n = 0;
    ack_cnt = 0;
    err_cnt = 0;
    for (int c = 0; c < N; c++) hi[c] = 0;
    do begin
      for (int c = 0; c < N; c++) if (pwm_out[c]) hi[c]++;
      wr_en = 1'b0;
      if (nwr >= 1 && n == at) begin
        wr_en = 1'b1; wr_ch = c0; wr_width = w0;
      end
      if (nwr >= 2 && n == at + 1) begin
        wr_en = 1'b1; wr_ch = c1; wr_width = w1;
      end
      @(negedge clk);
      n++;
      ack_cnt += int'(wr_ack);
      err_cnt += int'(wr_err);
    end while (!frame_start && n < 4000);
    wr_en = 1'b0;
    period = n;
  endtask

  task automatic check_frame(input int f, input int exp_ack, input int exp_err);
    for (int c = 0; c < N; c++) begin
      chk($sformatf("F%0d_ch%0d_high", f + 1, c), hi[c], exp_w[f][c] * 10);
    end
    chk($sformatf("F%0d_period", f + 1), period, 2000);
    chk($sformatf("F%0d_ack", f + 1), ack_cnt, exp_ack);
    chk($sformatf("F%0d_err", f + 1), err_cnt, exp_err);
  endtask

  // Releases reset on a falling edge and counts clocks to the first frame_start.
  task automatic release_and_wait(input string tag);
    int n;
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, "_first_pwm"}, int'(pwm_out), int'(ch_en));
    end while (!frame_start && n < 5000);
    chk({tag, "_first_frame"}, n, 2000);
  endtask

  initial begin
`ifdef SERVO_SLEW_EN
    exp_w = '{'{15, 15, 15, 15}, '{15, 15, 15, 15}, '{15, 17, 15, 15}, '{13, 19, 17, 15},
              '{11, 20, 19, 15}, '{9, 20, 21, 15}, '{7, 20, 23, 13}};
    slew_seq = '{15, 17, 19, 21, 23, 25, 25};
`else
    exp_w = '{'{15, 15, 15, 15}, '{15, 15, 15, 15}, '{15, 20, 15, 15}, '{5, 20, 25, 15},
              '{5, 20, 25, 15}, '{5, 20, 25, 15}, '{5, 20, 25, 10}};
    slew_seq = '{15, 25, 25, 25, 25, 25, 25};
`endif
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_ch = 4'd0;
    wr_width = 8'd0;
    ch_en = 4'hf;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_ack", int'(wr_ack), 0);
    chk("rst_err", int'(wr_err), 0);
    chk("rst_fs", int'(frame_start), 0);

    // Asynchronous reset mid-frame, asserted between clock edges.
    rst = 1'b0;
    @(negedge clk);
    chk("pre_rst_pwm_first", int'(pwm_out), 15);
    repeat (40) @(negedge clk);
    chk("pre_rst_pwm_mid", int'(pwm_out), 15);
    #2 rst = 1'b1;
    #1 chk("async_rst_pwm", int'(pwm_out), 0);
    @(negedge clk);
    release_and_wait("rel1");

    // F1 idle; F2 write ch1=20 mid-frame; F3 back-to-back clamped writes;
    // F4 invalid channel; F5 write ch3=10 on the wrap edge; F6, F7 idle.
    run_frame(0, 0, 4'd0, 8'd0, 4'd0, 8'd0);    check_frame(0, 0, 0);
    run_frame(1, 500, 4'd1, 8'd20, 4'd0, 8'd0); check_frame(1, 1, 0);
    run_frame(2, 300, 4'd0, 8'd3, 4'd2, 8'd40); check_frame(2, 2, 0);
    run_frame(1, 400, 4'd7, 8'd9, 4'd0, 8'd0);  check_frame(3, 1, 1);
    run_frame(1, 1999, 4'd3, 8'd10, 4'd0, 8'd0); check_frame(4, 1, 0);
    run_frame(0, 0, 4'd0, 8'd0, 4'd0, 8'd0);    check_frame(5, 0, 0);
    run_frame(0, 0, 4'd0, 8'd0, 4'd0, 8'd0);    check_frame(6, 0, 0);

    // Enable gating early in a frame, where every channel is high.
    repeat (30) @(negedge clk);
    chk("en_all_high", int'(pwm_out), 15);
    ch_en = 4'b1011;
    @(negedge clk);
    chk("en_drop_ch2", int'(pwm_out), 11);
    ch_en = 4'hf;
    @(negedge clk);
    chk("en_resume_ch2", int'(pwm_out), 15);

    // Fresh reset, then ch0 from 15 toward 25.
    rst = 1'b1;
    @(negedge clk);
    release_and_wait("rel2");
    run_frame(1, 100, 4'd0, 8'd25, 4'd0, 8'd0);
    chk("slew_f0_ch0", hi[0], slew_seq[0] * 10);
    chk("slew_f0_ack", ack_cnt, 1);
    for (int k = 1; k < 7; k++) begin
      run_frame(0, 0, 4'd0, 8'd0, 4'd0, 8'd0);
      chk($sformatf("slew_f%0d_ch0", k), hi[0], slew_seq[k] * 10);
    end
    chk("slew_ch1_untouched", hi[1], 150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
